// File: rtl/cpu_run_controller.sv
// Sequences one MIPS CPU test run: reset pulse, active-cycle counting, register_v0 capture.
// Optional watchdog abort is compiled in when RUN_CTRL_TIMEOUT_EN is defined.
module cpu_run_controller #(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        cpu_reset,
    input  logic        cpu_active,
    input  logic [31:0] cpu_register_v0,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic [31:0] result,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_PULSE = 3'd1,
        S_WAIT_ACT  = 3'd2,
        S_RUNNING   = 3'd3,
        S_ABORT     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);

    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("cpu_run_controller: need RESET_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
    end

    state_t      state_q, state_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timed_out_q, timed_out_d;
    logic [31:0] result_q, result_d;
    logic [31:0] cycle_count_q, cycle_count_d;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] idle_cnt_q, idle_cnt_d;
`endif

    // Next-state and next-output computation for the run sequencer
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cpu_reset_d   = cpu_reset_q;
        done_d        = 1'b0;
        timed_out_d   = timed_out_q;
        result_d      = result_q;
        cycle_count_d = cycle_count_q;
`ifdef RUN_CTRL_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RST_PULSE;
                    rst_cnt_d     = 32'd0;
                    cpu_reset_d   = 1'b1;
                    timed_out_d   = 1'b0;
                    result_d      = 32'd0;
                    cycle_count_d = 32'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST_PULSE: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d     = S_WAIT_ACT;
                    cpu_reset_d = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
                    idle_cnt_d  = 32'd0;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            S_WAIT_ACT: begin
                // The cycle in which active is first seen already counts
                if (cpu_active) begin
                    state_d       = S_RUNNING;
                    cycle_count_d = 32'd1;
                end
`ifdef RUN_CTRL_TIMEOUT_EN
                else if (idle_cnt_q == TO_LAST) begin
                    state_d     = S_ABORT;
                    rst_cnt_d   = 32'd0;
                    cpu_reset_d = 1'b1;
                    timed_out_d = 1'b1;
                    result_d    = 32'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
`else
                else begin
                    state_d = S_WAIT_ACT;
                end
`endif
            end
            S_RUNNING: begin
                // Completion is checked first so it wins over a simultaneous limit hit
                if (!cpu_active) begin
                    state_d  = S_DONE;
                    result_d = cpu_register_v0;
                    done_d   = 1'b1;
                end
`ifdef RUN_CTRL_TIMEOUT_EN
                else if (cycle_count_q >= TO_LAST) begin
                    state_d       = S_ABORT;
                    cycle_count_d = TO_LIMIT;
                    rst_cnt_d     = 32'd0;
                    cpu_reset_d   = 1'b1;
                    timed_out_d   = 1'b1;
                    result_d      = 32'd0;
                end
`endif
                else begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            S_ABORT: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d     = S_DONE;
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                cpu_reset_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; async reset forces IDLE mid-run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= 32'd0;
            cpu_reset_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            result_q      <= 32'd0;
            cycle_count_q <= 32'd0;
`ifdef RUN_CTRL_TIMEOUT_EN
            idle_cnt_q    <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cpu_reset_q   <= cpu_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timed_out_q   <= timed_out_d;
            result_q      <= result_d;
            cycle_count_q <= cycle_count_d;
`ifdef RUN_CTRL_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign result      = result_q;
    assign cycle_count = cycle_count_q;

endmodule
